// File: rtl/deadtime_monitor_pkg.sv
// Shared types and defaults for the dead-time monitor and the status logic that reads it.
package deadtime_monitor_pkg;

    localparam int DTCOUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_ON,
        S_B_ON,
        S_DT_AB,
        S_DT_BA,
        S_FAULT
    } dtmon_state_e;

endpackage

// File: rtl/deadtime_monitor.sv
// Watches one complementary gate pair, measures the dead time at every commutation
// and latches shoot-through and minimum-dead-time violations.
module deadtime_monitor
    import deadtime_monitor_pkg::*;
#(
    parameter int DTW = DTCOUNT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           gate_A,
    input  logic           gate_B,
    input  logic           logic_A,
    input  logic           logic_B,
    input  logic           en,
    input  logic [DTW-1:0] dt_min,
    input  logic           clear,
    output logic [DTW-1:0] dt_ab,
    output logic [DTW-1:0] dt_ba,
    output logic           dt_valid,
    output logic           dt_dir,
    output logic           dt_viol,
    output logic           shoot_fault
);

    logic           actA;
    logic           actB;
    dtmon_state_e   state_q;
    logic [DTW-1:0] cnt_q;
    logic [DTW-1:0] dtAb_q;
    logic [DTW-1:0] dtBa_q;
    logic           dtValid_q;
    logic           dtDir_q;
    logic           dtViol_q;
    logic           shootFault_q;

    logic [DTW-1:0] cntInc;
    logic           measFire;
    logic           measDir;
    logic [DTW-1:0] measVal;
    logic           measViol;

    assign actA = ~(gate_A ^ logic_A);
    assign actB = ~(gate_B ^ logic_B);

    assign cntInc = (cnt_q == {DTW{1'b1}}) ? cnt_q : cnt_q + DTW'(1);

    // A measurement completes when the opposite gate turns on, either straight
    // from the other gate (zero dead time) or after a counted dead interval.
    always_comb begin
        measFire = 1'b0;
        measDir  = 1'b0;
        measVal  = '0;
        unique case (state_q)
            S_A_ON:  if (!actA && actB) begin measFire = 1'b1; measDir = 1'b0; end
            S_B_ON:  if (actA && !actB) begin measFire = 1'b1; measDir = 1'b1; end
            S_DT_AB: if (!actA && actB) begin measFire = 1'b1; measDir = 1'b0; measVal = cnt_q; end
            S_DT_BA: if (actA && !actB) begin measFire = 1'b1; measDir = 1'b1; measVal = cnt_q; end
            default: ;
        endcase
    end

    assign measViol = (measVal < dt_min);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dtAb_q       <= '0;
            dtBa_q       <= '0;
            dtValid_q    <= 1'b0;
            dtDir_q      <= 1'b0;
            dtViol_q     <= 1'b0;
            shootFault_q <= 1'b0;
        end else begin
            dtValid_q <= 1'b0;
            if (!en) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else if (state_q == S_FAULT) begin
                if (clear && !actA && !actB) begin
                    state_q      <= S_IDLE;
                    shootFault_q <= 1'b0;
                    dtViol_q     <= 1'b0;
                end
            end else if (actA && actB) begin
                // Shoot-through beats every other transition; the set also beats a clear.
                state_q      <= S_FAULT;
                cnt_q        <= '0;
                shootFault_q <= 1'b1;
                if (clear) dtViol_q <= 1'b0;
            end else begin
                if (clear) begin
                    dtViol_q     <= 1'b0;
                    shootFault_q <= 1'b0;
                end
                if (measFire) begin
                    dtValid_q <= 1'b1;
                    dtDir_q   <= measDir;
                    if (measDir) dtBa_q <= measVal;
                    else         dtAb_q <= measVal;
                    if (measViol) dtViol_q <= 1'b1;
                end
                unique case (state_q)
                    S_IDLE: begin
                        if (actA)      state_q <= S_A_ON;
                        else if (actB) state_q <= S_B_ON;
                    end
                    S_A_ON: begin
                        if (!actA) begin
                            if (actB) state_q <= S_B_ON;
                            else begin
                                state_q <= S_DT_AB;
                                cnt_q   <= DTW'(1);
                            end
                        end
                    end
                    S_B_ON: begin
                        if (!actB) begin
                            if (actA) state_q <= S_A_ON;
                            else begin
                                state_q <= S_DT_BA;
                                cnt_q   <= DTW'(1);
                            end
                        end
                    end
                    S_DT_AB: begin
                        if (actB)      state_q <= S_B_ON;
                        else if (actA) state_q <= S_A_ON;
                        else           cnt_q   <= cntInc;
                    end
                    S_DT_BA: begin
                        if (actA)      state_q <= S_A_ON;
                        else if (actB) state_q <= S_B_ON;
                        else           cnt_q   <= cntInc;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign dt_ab       = dtAb_q;
    assign dt_ba       = dtBa_q;
    assign dt_valid    = dtValid_q;
    assign dt_dir      = dtDir_q;
    assign dt_viol     = dtViol_q;
    assign shoot_fault = shootFault_q;

endmodule

// File: tb/tb_deadtime_monitor.sv
// Directed scoreboard bench for deadtime_monitor: stimulus queues expected pulses,
// a negedge monitor pops and compares them.
module tb_deadtime_monitor;

    localparam int DTW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           gate_A = 1'b0;
    logic           gate_B = 1'b0;
    logic           logic_A = 1'b1;
    logic           logic_B = 1'b1;
    logic           en = 1'b1;
    logic [DTW-1:0] dt_min = '0;
    logic           clear = 1'b0;
    logic [DTW-1:0] dt_ab;
    logic [DTW-1:0] dt_ba;
    logic           dt_valid;
    logic           dt_dir;
    logic           dt_viol;
    logic           shoot_fault;

    typedef struct packed {
        logic           dir;
        logic [DTW-1:0] val;
        logic           viol;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    deadtime_monitor #(.DTW(DTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .gate_A      (gate_A),
        .gate_B      (gate_B),
        .logic_A     (logic_A),
        .logic_B     (logic_B),
        .en          (en),
        .dt_min      (dt_min),
        .clear       (clear),
        .dt_ab       (dt_ab),
        .dt_ba       (dt_ba),
        .dt_valid    (dt_valid),
        .dt_dir      (dt_dir),
        .dt_viol     (dt_viol),
        .shoot_fault (shoot_fault)
    );

    always #5 clk = ~clk;

    // Drive the active levels for n sampled edges; pins follow the polarity setting.
    task automatic applyStimulus(input logic actA, input logic actB, input int n);
        for (int i = 0; i < n; i++) begin
            gate_A = actA ^ ~logic_A;
            gate_B = actB ^ ~logic_B;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectPulse(input logic dir, input logic [DTW-1:0] val, input logic viol);
        exp_t e;
        e.dir  = dir;
        e.val  = val;
        e.viol = viol;
        expQ.push_back(e);
    endtask

    task automatic checkDrained(input string name);
        @(negedge clk);
        #1;
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " dt_ab"}, dt_ab, 0);
        checkOutput({tag, " dt_ba"}, dt_ba, 0);
        checkOutput({tag, " dt_valid"}, dt_valid, 0);
        checkOutput({tag, " dt_dir"}, dt_dir, 0);
        checkOutput({tag, " dt_viol"}, dt_viol, 0);
        checkOutput({tag, " shoot_fault"}, shoot_fault, 0);
    endtask

    // Scoreboard monitor: every dt_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dt_valid === 1'b1) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected pulse: got dir=%0d ab=%0d ba=%0d viol=%0d, expected none",
                         dt_dir, dt_ab, dt_ba, dt_viol);
            end else begin
                exp_t e;
                logic [DTW-1:0] got;
                e = expQ.pop_front();
                got = dt_dir ? dt_ba : dt_ab;
                if (dt_dir !== e.dir || got !== e.val || dt_viol !== e.viol) begin
                    miscompares++;
                    $display("[TB] FAIL pulse: got dir=%0d val=%0d viol=%0d, expected dir=%0d val=%0d viol=%0d",
                             dt_dir, got, dt_viol, e.dir, e.val, e.viol);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dt_min = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        reset = 1'b0;

        // Basic A->B and B->A measurements, no violations at dt_min=3
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 5);
        expectPulse(1'b0, 4'd5, 1'b0);
        applyStimulus(0, 1, 1);
        checkDrained("pulse ab=5");
        checkOutput("dt_ab basic", dt_ab, 5);
        checkOutput("dt_viol basic", dt_viol, 0);
        applyStimulus(0, 1, 3);
        applyStimulus(0, 0, 4);
        expectPulse(1'b1, 4'd4, 1'b0);
        applyStimulus(1, 0, 1);
        checkDrained("pulse ba=4");
        checkOutput("dt_ba basic", dt_ba, 4);

        // Violation at dt_min=8, clear, then clear colliding with a new violation
        dt_min = 4'd8;
        applyStimulus(1, 0, 2);
        applyStimulus(0, 0, 5);
        expectPulse(1'b0, 4'd5, 1'b1);
        applyStimulus(0, 1, 1);
        checkDrained("pulse viol");
        checkOutput("dt_viol set", dt_viol, 1);
        clear = 1'b1;
        applyStimulus(0, 1, 1);
        clear = 1'b0;
        checkOutput("dt_viol cleared", dt_viol, 0);
        applyStimulus(0, 0, 5);
        expectPulse(1'b1, 4'd5, 1'b1);
        clear = 1'b1;
        applyStimulus(1, 0, 1);
        clear = 1'b0;
        checkDrained("pulse viol vs clear");
        checkOutput("dt_viol set wins", dt_viol, 1);

        // Direct swaps with zero dead time
        dt_min = 4'd2;
        clear = 1'b1;
        applyStimulus(1, 0, 1);
        clear = 1'b0;
        checkOutput("dt_viol pre-swap", dt_viol, 0);
        expectPulse(1'b0, 4'd0, 1'b1);
        applyStimulus(0, 1, 1);
        checkDrained("pulse swap ab");
        checkOutput("dt_ab swap", dt_ab, 0);
        checkOutput("dt_viol swap", dt_viol, 1);
        expectPulse(1'b1, 4'd0, 1'b1);
        applyStimulus(1, 0, 1);
        checkDrained("pulse swap ba");
        checkOutput("dt_ba swap", dt_ba, 0);

        // Shoot-through, clear while a gate is still on, then a full clear
        applyStimulus(1, 0, 2);
        applyStimulus(1, 1, 1);
        checkOutput("shoot_fault set", shoot_fault, 1);
        clear = 1'b1;
        applyStimulus(1, 0, 1);
        checkOutput("shoot_fault held", shoot_fault, 1);
        applyStimulus(0, 0, 1);
        clear = 1'b0;
        checkOutput("shoot_fault cleared", shoot_fault, 0);
        clear = 1'b1;
        applyStimulus(0, 0, 1);
        clear = 1'b0;
        checkOutput("dt_viol idle clear", dt_viol, 0);

        // Saturation and a same-gate return
        dt_min = 4'd0;
        applyStimulus(1, 0, 3);
        applyStimulus(0, 0, 20);
        expectPulse(1'b0, 4'd15, 1'b0);
        applyStimulus(0, 1, 1);
        checkDrained("pulse saturated");
        checkOutput("dt_ab saturated", dt_ab, 15);
        checkOutput("dt_viol dt_min=0", dt_viol, 0);
        applyStimulus(0, 0, 3);
        applyStimulus(0, 1, 2);
        checkDrained("no pulse on return");
        checkOutput("dt_ba unchanged", dt_ba, 0);

        // Inverted pin polarity reproduces the first scenario
        reset = 1'b1;
        logic_A = 1'b0;
        logic_B = 1'b0;
        dt_min = 4'd3;
        applyStimulus(0, 0, 1);
        checkReset("reset inverted");
        reset = 1'b0;
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 5);
        expectPulse(1'b0, 4'd5, 1'b0);
        applyStimulus(0, 1, 1);
        checkDrained("pulse inverted");
        checkOutput("dt_ab inverted", dt_ab, 5);
        checkOutput("dt_viol inverted", dt_viol, 0);

        // Reset in the middle of a dead interval discards the count
        applyStimulus(0, 0, 3);
        #2;
        reset = 1'b1;
        #1;
        checkReset("reset mid-dt");
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 0, 2);
        applyStimulus(1, 0, 1);
        checkDrained("no pulse after reset");
        applyStimulus(0, 0, 2);
        expectPulse(1'b0, 4'd2, 1'b1);
        applyStimulus(0, 1, 1);
        checkDrained("pulse after reset");
        checkOutput("dt_ab after reset", dt_ab, 2);

        applyStimulus(0, 1, 3);
        checkOutput("queue empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
